dvp_pattern_tx: RTL

Synthesizable OV7670-style DVP (parallel camera) transmitter. It generates pclk, vsync, href and 8-bit RGB565 byte data from an internal test-pattern generator. It drives the camera-side input pins of the capture path (cam_clock, cam_vsync, cam_href, cam_data_wires) in place of the physical sensor, so capture, buffer and VGA display can be brought up and regressed without a camera.

---
 rtl/dvp_pattern_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dvp_pattern_tx.sv
// DVP camera-side transmitter driven by an internal test-pattern generator.
// Optional DVP_TX_SCROLL_EN: horizontal scroll by one pixel per frame.
module dvp_pattern_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 144,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int SLOTS = 2 * (H_ACTIVE + H_BLANK);
  localparam int SW    = $clog2(SLOTS);
  localparam int LSUM  = V_ACTIVE + VS_LINES + VBP_LINES + VFP_LINES;
  localparam int LW    = ($clog2(LSUM) > 4) ? $clog2(LSUM) : 4;
  localparam int XW    = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [SW-1:0] HREF_END  = SW'(2 * H_ACTIVE);
  localparam logic [XW-1:0] BAR_W     = XW'(H_ACTIVE / 8);

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBP, ACTIVE, VFP
  } state_t;

  state_t      state, n_state;
  logic        ph;
  logic [SW-1:0] slot, n_slot;
  logic [LW-1:0] line, n_line, lim;
  logic        start, done;
  logic [1:0]  pat_q;
  logic [15:0] solid_q;
  logic [XW-1:0] x_raw, x_eff;
  logic [2:0]  bar;
  logic [7:0]  g;
  logic [15:0] pix;
  logic        n_href;
  logic [7:0]  n_byte;

  assign pclk = ph;

  always_comb begin
    unique case (state)
      VSYNC:   lim = LW'(VS_LINES - 1);
      VBP:     lim = LW'(VBP_LINES - 1);
      ACTIVE:  lim = LW'(V_ACTIVE - 1);
      default: lim = LW'(VFP_LINES - 1);
    endcase
  end

  always_comb begin
    n_state = state;
    n_slot  = slot;
    n_line  = line;
    start   = 1'b0;
    done    = 1'b0;
    if (state == IDLE) begin
      if (enable) begin
        n_state = VSYNC;
        n_slot  = '0;
        n_line  = '0;
        start   = 1'b1;
      end
    end else if (slot != SLOT_LAST) begin
      n_slot = slot + 1'b1;
    end else begin
      n_slot = '0;
      n_line = line + 1'b1;
      if (line == lim) begin
        n_line = '0;
        case (state)
          VSYNC:  n_state = VBP;
          VBP:    n_state = ACTIVE;
          ACTIVE: n_state = VFP;
          default: begin
            done = 1'b1;
            if (enable) begin
              n_state = VSYNC;
              start   = 1'b1;
            end else begin
              n_state = IDLE;
            end
          end
        endcase
      end
    end
  end

  assign x_raw = XW'(n_slot[SW-1:1]);

`ifdef DVP_TX_SCROLL_EN
  localparam logic [XW:0]   HA_W  = (XW+1)'(H_ACTIVE);
  localparam logic [XW-1:0] HA_M1 = XW'(H_ACTIVE - 1);
  logic [XW-1:0] offset, off_q;
  logic [XW:0]   x_sum;

  assign x_sum = {1'b0, x_raw} + {1'b0, off_q};
  assign x_eff = (x_sum >= HA_W) ? XW'(x_sum - HA_W) : XW'(x_sum);

  // off_q holds this frame's shift; offset is already the next frame's
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
      off_q  <= '0;
    end else if (ph && start) begin
      off_q  <= offset;
      offset <= (offset == HA_M1) ? '0 : offset + 1'b1;
    end
  end
`else
  assign x_eff = x_raw;
`endif

  assign bar = 3'(x_eff / BAR_W);
  assign g   = x_eff[7:0];

  always_comb begin
    unique case (bar)
      3'd0:    pix = 16'hFFFF;
      3'd1:    pix = 16'hFFE0;
      3'd2:    pix = 16'h07FF;
      3'd3:    pix = 16'h07E0;
      3'd4:    pix = 16'hF81F;
      3'd5:    pix = 16'hF800;
      3'd6:    pix = 16'h001F;
      default: pix = 16'h0000;
    endcase
    unique case (pat_q)
      2'd0:    ;
      2'd1:    pix = {g[7:3], g[7:2], g[7:3]};
      2'd2:    pix = (x_eff[3] ^ n_line[3]) ? 16'hFFFF : 16'h0000;
      default: pix = solid_q;
    endcase
  end

  assign n_href = (n_state == ACTIVE) && (n_slot < HREF_END);
  assign n_byte = n_slot[0] ? pix[7:0] : pix[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= 1'b0;
      state       <= IDLE;
      slot        <= '0;
      line        <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
    end else begin
      ph          <= ~ph;
      frame_start <= 1'b0;
      if (ph) begin
        state <= n_state;
        slot  <= n_slot;
        line  <= n_line;
        vsync <= (n_state == VSYNC);
        href  <= n_href;
        data  <= n_href ? n_byte : 8'h00;
        if (start) begin
          frame_start <= 1'b1;
          busy        <= 1'b1;
          pat_q       <= pattern_sel;
          solid_q     <= solid_rgb;
        end else if (n_state == IDLE) begin
          busy <= 1'b0;
        end
        if (done) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
